// File: rtl/posit_div_iter.sv
// posit_div_iter: iterative posit<N,es> divider, quotient = in1 / in2.
// One operation at a time under a start/busy/done handshake. The operands are
// decoded, their hidden-bit fractions go through a restoring radix-2 divide
// (one quotient bit per cycle), and the result is re-encoded with truncation
// and saturation to minpos/maxpos.
// Ports:
//   aclk, aresetn      clock (rising edge), asynchronous active-low reset
//   start, in1, in2    request and operands; start is sampled only while busy=0
//   busy               operation in progress
//   done               one-cycle pulse; result/inf/zero are valid from here on
//   result, inf, zero  quotient posit, NaR flag, zero flag (held until next done)
module posit_div_iter #(
  parameter int N  = 16,
  parameter int es = 3
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         start,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         inf,
  output logic         zero
);
  localparam int Bs = $clog2(N);
  localparam int Q  = N - es + 2;
  localparam int FW = N - es + 1;
  localparam int SW = es + Bs + 2;
  localparam int CW = $clog2(Q);
  localparam int TW = 2 + es + Q - 1;

  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] KLIM = SW'(N - 2);

  typedef enum logic [2:0] {IDLE, DECODE, DIVIDE, PACK, DONE} state_t;
  state_t state, state_next;

  logic [N-1:0]         op1, op2;
  logic                 sign;
  logic signed [SW-1:0] scale_diff;
  logic [FW:0]          rem;
  logic [FW-1:0]        divisor;
  logic [Q-1:0]         quo;
  logic [CW-1:0]        cnt;

  // Returns {scale, fraction-with-hidden-bit}, where scale = k*2^es + e.
  // Exponent/fraction bits pushed off the end by a long regime read as zero.
  function automatic logic [SW+FW-1:0] decode(input logic [N-1:0] p);
    logic [N-2:0]         mag, sh;
    logic                 rc, stop;
    logic [Bs:0]          run, shamt;
    logic signed [SW-1:0] kr, k;
    logic [es-1:0]        e;
    mag  = p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
    rc   = mag[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (mag[i] == rc)) run = run + 1'b1;
      else stop = 1'b1;
    end
    shamt = run + 1'b1;
    sh    = mag << shamt;
    kr    = $signed({{(SW-Bs-1){1'b0}}, run});
    k     = rc ? (kr - SW'(1)) : -kr;
    e     = sh[N-2 -: es];
    return {k[SW-es-1:0], e, 1'b1, sh[N-es-2:0], 1'b0};
  endfunction

  logic [SW+FW-1:0] dec1, dec2;
  logic             nar_case, special;

  assign dec1     = decode(op1);
  assign dec2     = decode(op2);
  assign nar_case = (op1 == NAR) || (op2 == NAR) || (op2 == '0);
  assign special  = nar_case || (op1 == '0);

  // Re-encoding. A quotient below 1 is renormalised by one bit. The regime is
  // formed by an arithmetic shift of a 2-bit seed: "10" smears ones for k>=0,
  // "01" smears zeros for k<0; floor(D/2^es) gives the negative-D borrow.
  logic signed [SW-1:0] d_adj, k_out, run_out;
  logic [es-1:0]        e_out;
  logic [Q-2:0]         frac_out;
  logic signed [TW-1:0] packed_v, shifted;
  logic [N-2:0]         mag_out;
  logic [N-1:0]         packed_res;
  logic                 pack_unused;

  always_comb begin
    frac_out = quo[Q-1] ? quo[Q-2:0] : {quo[Q-3:0], 1'b0};
    d_adj    = quo[Q-1] ? scale_diff : scale_diff - SW'(1);
    k_out    = d_adj >>> es;
    e_out    = d_adj[es-1:0];
    run_out  = k_out[SW-1] ? ~k_out : k_out;
    packed_v = {(k_out[SW-1] ? 2'b01 : 2'b10), e_out, frac_out};
    shifted  = packed_v >>> run_out;
    mag_out  = shifted[TW-1 -: N-1];
    if (k_out >= KLIM) mag_out = MAXPOS[N-2:0];
    else if (k_out <= -KLIM) mag_out = MINPOS[N-2:0];
    packed_res = sign ? (~{1'b0, mag_out} + 1'b1) : {1'b0, mag_out};
  end

  // Bits below the posit's precision are truncated away.
  assign pack_unused = ^shifted[TW-N:0];

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? DECODE : IDLE;
      DECODE:     state_next = special ? DONE : DIVIDE;
      DIVIDE:     if (cnt == CW'(Q - 1)) state_next = PACK;
      PACK:       state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DECODE, DIVIDE, PACK: busy = 1'b1;
      DONE:                 done = 1'b1;
      default:              ;
    endcase
  end

  // Datapath: operand latch, decode, one restoring step per DIVIDE cycle,
  // and the result registers that hold until the next completion.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op1        <= '0;
      op2        <= '0;
      sign       <= 1'b0;
      scale_diff <= '0;
      rem        <= '0;
      divisor    <= '0;
      quo        <= '0;
      cnt        <= '0;
      result     <= '0;
      inf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op1 <= in1;
            op2 <= in2;
          end
        end
        DECODE: begin
          sign       <= op1[N-1] ^ op2[N-1];
          scale_diff <= $signed(dec1[SW+FW-1 -: SW]) - $signed(dec2[SW+FW-1 -: SW]);
          rem        <= {1'b0, dec1[FW-1:0]};
          divisor    <= dec2[FW-1:0];
          quo        <= '0;
          cnt        <= '0;
          if (nar_case) begin
            result <= NAR;
            inf    <= 1'b1;
            zero   <= 1'b0;
          end else if (op1 == '0) begin
            result <= '0;
            inf    <= 1'b0;
            zero   <= 1'b1;
          end
        end
        DIVIDE: begin
          if (rem >= {1'b0, divisor}) begin
            rem <= {rem[FW-1:0] - divisor, 1'b0};
            quo <= {quo[Q-2:0], 1'b1};
          end else begin
            rem <= {rem[FW-1:0], 1'b0};
            quo <= {quo[Q-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        PACK: begin
          result <= packed_res;
          inf    <= 1'b0;
          zero   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/posit_div_iter.md
Name: posit_div_iter

Overview:
Iterative posit divider that computes quotient = in1 / in2 for posit<N,es> operands, with the same number format as the pipelined posit multiplier.
It handles one operation at a time and uses a start/busy/done handshake.
It decodes both operands, runs a restoring radix-2 division of the hidden-bit fractions, then re-encodes the result.
It sits beside the multiplier in the PairHMM posit datapath, where it is used for normalisation/scaling divides that are not throughput-critical.

Parameters:
N, 16, posit width in bits
es, 3, exponent field width
Bs, log2(N), regime-count width
Q, N-es+2, quotient bits produced (hidden bit + fraction + one normalisation bit)

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
in1  in  N  dividend posit
in2  in  N  divisor posit
busy  out  1  operation in progress; start ignored while high
done  out  1  one-cycle pulse; result/inf/zero valid in this cycle and held afterwards
result  out  N  quotient posit
inf  out  1  result is NaR
zero  out  1  result is zero

Behaviour:
- Reset (aresetn=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, inf=0, zero=0.
  - Any operation in flight is discarded; no done pulse follows.
- States: IDLE, DECODE, DIVIDE, PACK, DONE.
- IDLE/DONE:
  - start=1 latches in1/in2 and goes to DECODE; busy=1 from the next cycle.
  - A start in the DONE cycle is accepted (back-to-back operation).
  - Otherwise DONE goes to IDLE.
- DECODE (1 cycle):
  - Sign = s1^s2.
  - Two's-complement negate negative operands.
  - Extract regime k, exponent e and fraction with hidden bit (N-es+1 bits).
  - Scale difference D = (k1·2^es + e1) − (k2·2^es + e2), signed, es+Bs+2 bits.
  - Special cases:
    - in1 or in2 = 0x8000 (NaR), or in2 = 0: go to DONE with result=0x8000, inf=1.
    - Otherwise, in1 = 0: go to DONE with result=0, zero=1.
  - Special-case latency: done 2 cycles after the accepting edge.
- DIVIDE (exactly Q cycles):
  - Restoring division: remainder initialised to fraction1, divisor = fraction2.
  - Each cycle: compare, subtract if remainder ≥ divisor, shift the quotient bit in (MSB first), shift the remainder left 1.
  - An iteration counter counts 0..Q−1; exit to PACK after count Q−1.
- PACK (1 cycle):
  - If the quotient MSB is 0 (fraction ratio < 1): shift the quotient left 1 and set D = D − 1.
  - Split D into a regime run length and an unsigned exponent, using the multiplier's convention (negative D with a nonzero low es bits borrows 1 into the regime).
  - Build {regime, exponent, fraction} and right-shift by the regime length.
  - Truncate: round toward zero; the remainder is discarded.
  - Saturation: magnitude never underflows to 0 or overflows to NaR.
    - If |D| exceeds the maxpos range, clip to maxpos (0x7FFF).
    - If below the minpos range, clip to minpos (0x0001).
  - Apply the sign by two's-complement negation; go to DONE.
- DONE (1 cycle): done=1, busy=0.
- Latency and hold:
  - Normal latency: done asserted Q+3 = 18 edges after the accepting edge.
  - result/inf/zero hold their value until the next DONE.
- Ordering and flags:
  - inf and zero are mutually exclusive.
  - inf takes precedence over zero when in1=0 and in2=0.
- Input values (X in simulation): treated as 0 when latched.

Test Plan:
- 0x4000 / 0x4000 (1.0/1.0) -> done at edge 18 after accept; result=0x4000, inf=0, zero=0.
- 0x4000 / 0x4400 (1.0/2.0) -> 0x3C00 (0.5); 0xC000 / 0x4400 (−1.0/2.0) -> 0xC400; 0x4200 / 0x4000 (1.5/1.0) -> 0x4200.
- 0x4000 / 0x0000 -> result=0x8000, inf=1, done 2 cycles after accept; 0x0000 / 0x0000 -> inf=1, zero=0; 0x0000 / 0x4400 -> result=0x0000, zero=1.
- Saturation: 0x7FFF / 0x0001 -> 0x7FFF; 0x0001 / 0x7FFF -> 0x0001; 0x8001 / 0x0001 -> 0x8001.
- Handshake:
  - A second start with different operands at cycles 5 and 10 of a busy operation -> ignored; the first result is unchanged.
  - A start on the done cycle -> accepted; second done 18 cycles later.
- aresetn pulsed low at DIVIDE iteration 7 -> busy/done/result/inf/zero all 0 immediately; no done pulse; the next start completes normally with the correct value.
